// File: rtl/mu0_reg_bank.sv
// MU0 register bank: DEPTH x WIDTH registers with in-place load/inc/dec/clear,
// two combinational read ports with optional same-cycle forwarding, registered Wrap/Zero flags.
module mu0_reg_bank #(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned DEPTH  = 8,
  parameter  bit          BYPASS = 1'b1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic [1:0]       Op,
  input  logic [AW-1:0]    WAddr,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    RAddrA,
  input  logic [AW-1:0]    RAddrB,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic             Wrap,
  output logic             Zero
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] result_c;
  logic             wrap_c;
  logic             zero_c;
  logic             fwd_a_c;
  logic             fwd_b_c;
  op_e              op_c;

  assign op_c    = op_e'(Op);
  assign cur_val = regs[WAddr];

  // Result and flags of the operation on the addressed register
  always_comb begin
    result_c = '0;
    wrap_c   = 1'b0;
    case (op_c)
      OP_LOAD: begin
        result_c = D;
      end
      OP_INC: begin
        result_c = cur_val + WIDTH'(1);
        wrap_c   = (cur_val == ALL_ONES);
      end
      OP_DEC: begin
        result_c = cur_val - WIDTH'(1);
        wrap_c   = (cur_val == '0);
      end
      OP_CLR: begin
        result_c = '0;
      end
      default: begin
        result_c = '0;
      end
    endcase
    zero_c = (result_c == '0);
  end

  // Register array and flags; reset clears everything and blocks a coincident write
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      Wrap <= 1'b0;
      Zero <= 1'b0;
    end else if (En) begin
      regs[WAddr] <= result_c;
      Wrap        <= wrap_c;
      Zero        <= zero_c;
    end
  end

  // Forwarding is suppressed while in reset so the ports read the cleared array
  assign fwd_a_c = BYPASS && Reset_n && En && (RAddrA == WAddr);
  assign fwd_b_c = BYPASS && Reset_n && En && (RAddrB == WAddr);

  assign QA = fwd_a_c ? result_c : regs[RAddrA];
  assign QB = fwd_b_c ? result_c : regs[RAddrB];

endmodule

// File: tb/tb_mu0_reg_bank.sv
// Self-checking bench for mu0_reg_bank: a forwarding and a non-forwarding instance
// share stimulus and are compared every cycle against an arithmetic reference model.
module tb_mu0_reg_bank;
  localparam int unsigned W  = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;

  logic          Clk     = 1'b0;
  logic          Reset_n = 1'b1;
  logic          En      = 1'b0;
  logic [1:0]    Op      = 2'b00;
  logic [AW-1:0] WAddr   = '0;
  logic [AW-1:0] RAddrA  = '0;
  logic [AW-1:0] RAddrB  = '0;
  logic [W-1:0]  D       = '0;

  logic [W-1:0] qa_b, qb_b, qa_n, qb_n;
  logic         wrap_b, zero_b, wrap_n, zero_n;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  int unsigned mem [N];
  bit          m_wrap;
  bit          m_zero;

  always #5 Clk = ~Clk;

  mu0_reg_bank #(.WIDTH(W), .DEPTH(N), .BYPASS(1'b1)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .Op(Op), .WAddr(WAddr), .D(D),
    .RAddrA(RAddrA), .RAddrB(RAddrB), .QA(qa_b), .QB(qb_b), .Wrap(wrap_b), .Zero(zero_b)
  );

  mu0_reg_bank #(.WIDTH(W), .DEPTH(N), .BYPASS(1'b0)) dut_n (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .Op(Op), .WAddr(WAddr), .D(D),
    .RAddrA(RAddrA), .RAddrB(RAddrB), .QA(qa_n), .QB(qb_n), .Wrap(wrap_n), .Zero(zero_n)
  );

  // Operation semantics with plain modular arithmetic
  function automatic void calc(input logic [1:0] op, input int unsigned v, input int unsigned d,
                               output int unsigned r, output bit w);
    case (op)
      2'd0:    begin r = d;                   w = 1'b0;        end
      2'd1:    begin r = (v + 1) % 65536;     w = (v == 65535); end
      2'd2:    begin r = (v + 65535) % 65536; w = (v == 0);     end
      default: begin r = 0;                   w = 1'b0;        end
    endcase
  endfunction

  function automatic int unsigned exp_q(input logic [AW-1:0] ra, input bit byp);
    int unsigned r;
    bit          w;
    if (byp && Reset_n && En && ra == WAddr) begin
      calc(Op, mem[WAddr], 32'(D), r, w);
      return r;
    end
    return mem[ra];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_on) begin
      chk("qa_byp",   32'(qa_b),   exp_q(RAddrA, 1'b1));
      chk("qb_byp",   32'(qb_b),   exp_q(RAddrB, 1'b1));
      chk("wrap_byp", 32'(wrap_b), 32'(m_wrap));
      chk("zero_byp", 32'(zero_b), 32'(m_zero));
      chk("qa_nob",   32'(qa_n),   exp_q(RAddrA, 1'b0));
      chk("qb_nob",   32'(qb_n),   exp_q(RAddrB, 1'b0));
      chk("wrap_nob", 32'(wrap_n), 32'(m_wrap));
      chk("zero_nob", 32'(zero_n), 32'(m_zero));
    end
  end

  task automatic model_reset();
    Reset_n = 1'b0;
    for (int i = 0; i < int'(N); i++) mem[i] = 0;
    m_wrap = 1'b0;
    m_zero = 1'b0;
  endtask

  task automatic drive(input bit en, input logic [1:0] op, input logic [AW-1:0] wa,
                       input logic [W-1:0] d, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    En = en; Op = op; WAddr = wa; D = d; RAddrA = ra; RAddrB = rb;
  endtask

  // Runs to just after the next rising edge, committing that edge into the model
  task automatic finish_cycle();
    int unsigned r;
    bit          w;
    @(negedge Clk);
    @(posedge Clk);
    if (Reset_n && En) begin
      calc(Op, mem[WAddr], 32'(D), r, w);
      mem[WAddr] = r;
      m_wrap     = w;
      m_zero     = (r == 0);
    end
    #1;
  endtask

  task automatic step(input bit en, input logic [1:0] op, input logic [AW-1:0] wa,
                      input logic [W-1:0] d, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    drive(en, op, wa, d, ra, rb);
    finish_cycle();
  endtask

  initial begin
    #1 model_reset();
    #1 cmp_on = 1'b1;
    finish_cycle();
    finish_cycle();
    chk("reset_qa", 32'(qa_n), 32'h0);
    chk("reset_wrap", 32'(wrap_n), 32'h0);
    chk("reset_zero", 32'(zero_n), 32'h0);
    Reset_n = 1'b1;

    // Mid-cycle reset clears a loaded register and a set Wrap flag
    step(1'b1, 2'd0, 3'd3, 16'hBEEF, 3'd3, 3'd7);
    step(1'b1, 2'd0, 3'd7, 16'hFFFF, 3'd3, 3'd7);
    step(1'b1, 2'd1, 3'd7, 16'h0000, 3'd3, 3'd7);
    chk("prerst_wrap", 32'(wrap_n), 32'h1);
    chk("prerst_r3", 32'(qa_n), 32'hBEEF);
    drive(1'b0, 2'd0, 3'd0, 16'h0, 3'd3, 3'd7);
    #2 model_reset();
    #1;
    chk("midrst_qa", 32'(qa_n), 32'h0);
    chk("midrst_qb", 32'(qb_n), 32'h0);
    chk("midrst_wrap", 32'(wrap_n), 32'h0);
    chk("midrst_zero", 32'(zero_n), 32'h0);
    finish_cycle();
    Reset_n = 1'b1;

    // Load/read and hold with En low
    step(1'b1, 2'd0, 3'd2, 16'h1234, 3'd2, 3'd5);
    step(1'b1, 2'd0, 3'd5, 16'h00FF, 3'd2, 3'd5);
    chk("load_qa", 32'(qa_n), 32'h1234);
    chk("load_qb", 32'(qb_n), 32'h00FF);
    chk("load_zero", 32'(zero_n), 32'h0);
    chk("load_wrap", 32'(wrap_n), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'($urandom), 3'($urandom), 16'($urandom), 3'd2, 3'd5);
    chk("hold_qa", 32'(qa_n), 32'h1234);
    chk("hold_qb", 32'(qb_n), 32'h00FF);

    // Increment wrap
    step(1'b1, 2'd0, 3'd1, 16'hFFFE, 3'd1, 3'd1);
    step(1'b1, 2'd1, 3'd1, 16'h0, 3'd1, 3'd1);
    chk("inc1_q", 32'(qa_n), 32'hFFFF);
    chk("inc1_wrap", 32'(wrap_n), 32'h0);
    chk("inc1_zero", 32'(zero_n), 32'h0);
    step(1'b1, 2'd1, 3'd1, 16'h0, 3'd1, 3'd1);
    chk("inc2_q", 32'(qa_n), 32'h0000);
    chk("inc2_wrap", 32'(wrap_n), 32'h1);
    chk("inc2_zero", 32'(zero_n), 32'h1);

    // Decrement wrap
    step(1'b1, 2'd3, 3'd0, 16'h5555, 3'd0, 3'd0);
    step(1'b1, 2'd2, 3'd0, 16'h0, 3'd0, 3'd0);
    chk("dec_q", 32'(qa_n), 32'hFFFF);
    chk("dec_wrap", 32'(wrap_n), 32'h1);
    chk("dec_zero", 32'(zero_n), 32'h0);
    step(1'b1, 2'd0, 3'd0, 16'h0, 3'd0, 3'd0);
    chk("ld0_zero", 32'(zero_n), 32'h1);
    chk("ld0_wrap", 32'(wrap_n), 32'h0);

    // Same-cycle forwarding vs stored-only read
    step(1'b1, 2'd0, 3'd4, 16'h0010, 3'd0, 3'd0);
    drive(1'b1, 2'd1, 3'd4, 16'h0, 3'd4, 3'd4);
    #2;
    chk("byp_qa", 32'(qa_b), 32'h0011);
    chk("byp_qb", 32'(qb_b), 32'h0011);
    chk("nob_pre_qa", 32'(qa_n), 32'h0010);
    chk("nob_pre_qb", 32'(qb_n), 32'h0010);
    finish_cycle();
    chk("nob_post_qa", 32'(qa_n), 32'h0011);

    // Reset held across a write edge blocks the write
    drive(1'b1, 2'd0, 3'd6, 16'hAAAA, 3'd6, 3'd6);
    #2 model_reset();
    finish_cycle();
    chk("rstwr_r6", 32'(qa_n), 32'h0);
    Reset_n = 1'b1;
    finish_cycle();
    chk("postrst_r6", 32'(qa_n), 32'hAAAA);

    // Randomised traffic with address collisions and occasional resets
    for (int i = 0; i < 500; i++) begin
      logic [AW-1:0] wa;
      wa = 3'($urandom);
      drive(($urandom_range(0, 3) != 0), 2'($urandom), wa,
            ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
            ($urandom_range(0, 1) == 0) ? wa : 3'($urandom),
            ($urandom_range(0, 1) == 0) ? wa : 3'($urandom));
      if ($urandom_range(0, 60) == 0) begin
        #2 model_reset();
        finish_cycle();
        Reset_n = 1'b1;
      end else begin
        finish_cycle();
      end
    end

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
